// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO that feeds a UART transmitter through a
// send/ready handshake. The FSM pops one byte, pulses tx_send, then waits
// for the transmitter to go busy and come back idle before the next pop.
module uart_tx_buffer #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          busy,
    output logic [7:0]    tx_data,
    output logic          tx_send,
    input  logic          tx_ready
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          full_c;
    logic          empty_c;
    logic          wr_acc;
    logic          wr_drop;
    logic          pop;

    // Occupancy flags and the accept/drop/pop decisions for this cycle.
    // Flush beats both a write and a pop; a write dropped by flush does not
    // count as an overflow.
    always_comb begin
        full_c  = (cnt == CW'(DEPTH));
        empty_c = (cnt == '0);
        wr_acc  = wr_en && !full_c && !flush;
        wr_drop = wr_en &&  full_c && !flush;
        pop     = (state == IDLE) && !empty_c && tx_ready && !flush;
    end

    assign full     = full_c;
    assign empty    = empty_c;
    assign count    = cnt;
    assign overflow = ovf;

    // Byte storage; gated by rst so writes presented during reset are ignored.
    always_ff @(posedge clk) begin
        if (rst && wr_acc)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers, occupancy count and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            // write+pop in one cycle nets to zero
            cnt <= cnt + CW'(wr_acc) - CW'(pop);
            if (wr_drop)
                ovf <= 1'b1;
        end
    end

    // Transmit handshake FSM with registered tx_send, tx_data and busy.
    // tx_data is only loaded on a pop, so it stays stable through the
    // whole SEND..WAIT_DONE sequence; flush never touches this block.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            tx_data <= 8'h00;
            tx_send <= 1'b0;
            busy    <= 1'b0;
        end else begin
            tx_send <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state   <= SEND;
                        tx_data <= mem[rd_ptr];
                        tx_send <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                SEND: begin
                    state <= WAIT_BUSY;
                end
                // Transmitter ready may stay high for a long time before the
                // baud clock picks up the byte; wait without any limit.
                WAIT_BUSY: begin
                    if (!tx_ready)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tx_ready) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_buffer.md
UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving FIFO depth in bytes; legal values are powers of two from 2 to 256.
REQ-002 The block SHALL have parameter CW, default $clog2(DEPTH)+1, giving the width of count.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic uses its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port wr_data, input, 8 bits: byte to enqueue.
REQ-006 The block SHALL have port wr_en, input, 1 bit: enqueue request for one clk cycle.
REQ-007 The block SHALL have port flush, input, 1 bit: discard all queued bytes.
REQ-008 The block SHALL have port full, output, 1 bit: asserted when count==DEPTH.
REQ-009 The block SHALL have port empty, output, 1 bit: asserted when count==0.
REQ-010 The block SHALL have port count, output, CW bits: number of queued bytes, excluding the byte in tx_data.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky flag, set on a dropped write.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-013 The block SHALL have port tx_data, output, 8 bits: byte presented to the UART transmitter data input.
REQ-014 The block SHALL have port tx_send, output, 1 bit: send pulse to the UART transmitter.
REQ-015 The block SHALL have port tx_ready, input, 1 bit: ready from the UART transmitter, high only when it is idle.

Function
REQ-016 A write SHALL be accepted iff wr_en=1, full=0 and flush=0 in that cycle; the byte is stored at the tail and count increments one cycle later.
REQ-017 wr_en=1 with full=1 and flush=0 SHALL drop the byte, leave the FIFO unchanged, and set overflow the next cycle.
REQ-018 overflow SHALL remain set until a reset, or until a cycle with flush=1.
REQ-019 flush=1 SHALL zero the pointers and count and clear overflow; flush wins over a simultaneous wr_en, which is dropped without setting overflow.
REQ-020 flush SHALL NOT alter the FSM state, tx_data or a transmission in progress.
REQ-021 The pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; full and empty derive from count.
REQ-022 A simultaneous accepted write and pop SHALL leave count unchanged.
REQ-023 The FSM SHALL have four states: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
REQ-024 IDLE -> SEND when empty=0, tx_ready=1 and flush=0: pop the head into tx_data and decrement count; otherwise remain in IDLE.
REQ-025 SEND SHALL assert tx_send for exactly one cycle, then go to WAIT_BUSY.
REQ-026 WAIT_BUSY -> WAIT_DONE on the first cycle with tx_ready=0; no cycle limit applies, because the transmitter's state changes on its slow baud-clock edge.
REQ-027 WAIT_DONE -> IDLE on the first cycle with tx_ready=1.
REQ-028 tx_data SHALL hold constant from SEND until the FSM leaves WAIT_DONE.
REQ-029 tx_send SHALL be registered and SHALL be 0 in every state except SEND.
REQ-030 Minimum latency from an accepted write to an empty idle block, with tx_ready=1, to tx_send=1 SHALL be 3 cycles: write cycle, IDLE pop, SEND.
REQ-031 A write accepted in the same cycle as a pop from a FIFO holding one byte SHALL be retained.
REQ-032 Bytes SHALL be transmitted in write order with no loss or duplication, except bytes dropped by overflow or flush.

Reset
REQ-033 rst=0 at a rising clk edge SHALL force IDLE, zero the pointers, and set outputs to: count=0, empty=1, full=0, overflow=0, busy=0, tx_send=0, tx_data=8'h00.
REQ-034 Reset mid-transmission SHALL abandon the byte in tx_data and discard the FIFO contents.
REQ-035 The block SHALL ignore tx_ready and wr_en while rst=0.

Verification
REQ-036 Single byte: write 8'hA5 to an idle block with tx_ready=1 -> tx_send pulses one cycle, 3 cycles after the write, with tx_data=8'hA5; the bench drops tx_ready 20 cycles later and raises it 200 cycles after that -> busy falls the cycle after tx_ready rises.
REQ-037 Fill: write 17 bytes 8'h00..8'h10 with DEPTH=16 and tx_ready=0 -> full=1 and count=16 after 16 writes; the 17th is dropped and overflow=1; a later flush gives count=0 and overflow=0.
REQ-038 Ordering: queue 8'h11, 8'h22, 8'h33 while the bench models the transmitter handshake -> exactly three tx_send pulses, with tx_data=8'h11, 8'h22, 8'h33 in order.
REQ-039 Long ready: hold tx_ready=1 for 1000 cycles after tx_send -> the block stays in WAIT_BUSY with no second tx_send; it completes normally once tx_ready toggles 0 then 1.
REQ-040 Reset mid-operation: rst=0 during WAIT_DONE with count=5 -> next cycle count=0, empty=1, busy=0, tx_data=8'h00, and no tx_send follows.
REQ-041 Simultaneous events: flush=1 with wr_en=1 during WAIT_BUSY -> count=0, overflow unchanged at 0, the FSM stays in WAIT_BUSY, and tx_data is unchanged.
